// File: rtl/uart_fifo.sv
// APB UART with 8N1 framing, programmable divisor, TX/RX FIFOs, CTS/RTS flow control,
// level interrupt and TX DMA request.
//   state   | meaning (shared by TX and RX FSMs)
//   S_IDLE  | line idle, waiting for data (TX) or a falling edge (RX)
//   S_START | start bit: TX drives 0; RX waits half a bit to confirm
//   S_DATA  | eight data bits, LSB first
//   S_STOP  | stop bit: TX drives 1; RX samples and pushes or flags

module uart_fifo_buf #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata,
    output logic [AW:0]   level,
    output logic          empty,
    output logic          full
);
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   lvl_q, lvl_d;
    logic          do_push, do_pop;

    assign empty = (lvl_q == '0);
    assign full  = (lvl_q == (AW+1)'(DEPTH));
    assign rdata = mem[rd_q];
    assign level = lvl_q;

    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    always_comb begin
        do_pop  = pop & ~empty;
        do_push = push & (~full | do_pop);
        wr_d    = wr_q + AW'(do_push);
        rd_d    = rd_q + AW'(do_pop);
        lvl_d   = lvl_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_q] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            lvl_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            lvl_q <= lvl_d;
        end
    end
endmodule

module uart_fifo #(
    parameter int               FIFO_DEPTH = 8,
    parameter int               DIV_W      = 16,
    parameter logic [DIV_W-1:0] DIV_RESET  = DIV_W'(868)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        apbs_psel,
    input  logic        apbs_penable,
    input  logic        apbs_pwrite,
    input  logic [15:0] apbs_paddr,
    input  logic [31:0] apbs_pwdata,
    output logic [31:0] apbs_prdata,
    output logic        apbs_pready,
    output logic        apbs_pslverr,
    input  logic        rx,
    output logic        tx,
    input  logic        cts,
    output logic        rts,
    output logic        irq,
    output logic        dreq
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_st_e;

    logic             txen_q, txen_d, rxen_q, rxen_d, ctsen_q, ctsen_d;
    logic             ovf_q, ovf_d, ferr_q, ferr_d;
    logic [2:0]       ie_q, ie_d;
    logic [DIV_W-1:0] div_q, div_d, div_eff;
    logic             rx_s1_q, rx_s2_q, rx_prev_q, cts_s1_q, cts_s2_q;

    uart_st_e         tx_st_q, tx_st_d, rx_st_q, rx_st_d;
    logic [DIV_W-1:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
    logic [DIV_W-1:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
    logic [2:0]       tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
    logic [7:0]       tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
    logic             tx_load, tx_go, tx_busy;

    logic       wr_en, rd_en, tx_push, tx_pop, rx_push, rx_pop, ovf_set, ferr_set;
    logic [2:0] idx;
    logic [7:0] tx_rdata, rx_rdata;
    logic [AW:0] tx_level, rx_level;
    logic       tx_empty, tx_full, rx_empty, rx_full;
    logic       unused_bits;

    assign idx         = apbs_paddr[4:2];
    assign wr_en       = apbs_psel & apbs_penable & apbs_pwrite;
    assign rd_en       = apbs_psel & apbs_penable & ~apbs_pwrite;
    assign tx_push     = wr_en & (idx == 3'd3);
    assign rx_pop      = rd_en & (idx == 3'd4) & ~rx_empty;
    assign apbs_pready = 1'b1;
    assign apbs_pslverr = apbs_psel & apbs_penable & (idx[2:1] == 2'b11);
    assign unused_bits = ^{apbs_paddr, apbs_pwdata};

    uart_fifo_buf #(.DEPTH(FIFO_DEPTH), .AW(AW)) u_tx_fifo (
        .clk(clk), .rst_n(rst_n), .push(tx_push), .pop(tx_pop), .wdata(apbs_pwdata[7:0]),
        .rdata(tx_rdata), .level(tx_level), .empty(tx_empty), .full(tx_full));

    uart_fifo_buf #(.DEPTH(FIFO_DEPTH), .AW(AW)) u_rx_fifo (
        .clk(clk), .rst_n(rst_n), .push(rx_push), .pop(rx_pop), .wdata(rx_sh_q),
        .rdata(rx_rdata), .level(rx_level), .empty(rx_empty), .full(rx_full));

    assign div_eff = (div_q < DIV_W'(4)) ? DIV_W'(4) : div_q;
    assign tx_busy = (tx_st_q != S_IDLE);
    assign tx_go   = txen_q & ~tx_empty & (~ctsen_q | ~cts_s2_q);
    assign tx      = (tx_st_q == S_START) ? 1'b0 : (tx_st_q == S_DATA) ? tx_sh_q[0] : 1'b1;
    assign rts     = (rx_level >= (AW+1)'(FIFO_DEPTH - 1)) | ~rxen_q;
    assign dreq    = txen_q & ~tx_full;
    assign irq     = |(ie_q & {ovf_q | ferr_q, ~rx_empty, tx_empty});

    always_comb begin
        apbs_prdata = 32'h0;
        if (apbs_psel && !apbs_pwrite) begin
            case (idx)
                3'd0: apbs_prdata = {17'h0, ferr_q, ovf_q, tx_busy, rx_full, rx_empty, tx_full,
                                     tx_empty, 5'h0, ctsen_q, rxen_q, txen_q};
                3'd1: apbs_prdata = 32'(div_q);
                3'd2: apbs_prdata = {16'h0, 8'(rx_level), 8'(tx_level)};
                3'd4: apbs_prdata = {23'h0, rx_empty, rx_empty ? 8'h00 : rx_rdata};
                3'd5: apbs_prdata = {29'h0, ie_q};
                default: apbs_prdata = 32'h0;
            endcase
        end
    end

    // Hardware set of a sticky flag wins over a same-cycle software clear.
    always_comb begin
        txen_d = txen_q; rxen_d = rxen_q; ctsen_d = ctsen_q;
        ovf_d  = ovf_q;  ferr_d = ferr_q; ie_d = ie_q; div_d = div_q;
        if (wr_en) begin
            case (idx)
                3'd0: begin
                    txen_d  = apbs_pwdata[0];
                    rxen_d  = apbs_pwdata[1];
                    ctsen_d = apbs_pwdata[2];
                    if (apbs_pwdata[13]) ovf_d  = 1'b0;
                    if (apbs_pwdata[14]) ferr_d = 1'b0;
                end
                3'd1: div_d = apbs_pwdata[DIV_W-1:0];
                3'd5: ie_d  = apbs_pwdata[2:0];
                default: ;
            endcase
        end
        if (ovf_set)  ovf_d  = 1'b1;
        if (ferr_set) ferr_d = 1'b1;
    end

    // STOP rolls straight into the next START when more data is ready: no idle gap.
    always_comb begin
        tx_st_d = tx_st_q; tx_cnt_d = tx_cnt_q; tx_bit_d = tx_bit_q;
        tx_sh_d = tx_sh_q; tx_div_d = tx_div_q; tx_pop = 1'b0; tx_load = 1'b0;
        case (tx_st_q)
            S_IDLE: tx_load = tx_go;
            S_START: begin
                tx_cnt_d = tx_cnt_q - DIV_W'(1);
                if (tx_cnt_q == '0) begin
                    tx_st_d = S_DATA; tx_cnt_d = tx_div_q - DIV_W'(1); tx_bit_d = 3'd0;
                end
            end
            S_DATA: begin
                tx_cnt_d = tx_cnt_q - DIV_W'(1);
                if (tx_cnt_q == '0) begin
                    tx_sh_d  = tx_sh_q >> 1;
                    tx_cnt_d = tx_div_q - DIV_W'(1);
                    tx_bit_d = tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'd7) tx_st_d = S_STOP;
                end
            end
            S_STOP: begin
                tx_cnt_d = tx_cnt_q - DIV_W'(1);
                if (tx_cnt_q == '0) begin
                    tx_st_d = S_IDLE;
                    tx_load = tx_go;
                end
            end
            default: tx_st_d = S_IDLE;
        endcase
        if (tx_load) begin
            tx_st_d  = S_START;
            tx_cnt_d = div_eff - DIV_W'(1);
            tx_div_d = div_eff;
            tx_sh_d  = tx_rdata;
            tx_pop   = 1'b1;
        end
    end

    always_comb begin
        rx_st_d = rx_st_q; rx_cnt_d = rx_cnt_q; rx_bit_d = rx_bit_q;
        rx_sh_d = rx_sh_q; rx_div_d = rx_div_q;
        rx_push = 1'b0; ovf_set = 1'b0; ferr_set = 1'b0;
        case (rx_st_q)
            S_IDLE: if (rx_prev_q && !rx_s2_q) begin
                rx_st_d  = S_START;
                rx_cnt_d = (div_eff >> 1) - DIV_W'(1);
                rx_div_d = div_eff;
            end
            S_START: begin
                rx_cnt_d = rx_cnt_q - DIV_W'(1);
                if (rx_cnt_q == '0) begin
                    rx_st_d  = rx_s2_q ? S_IDLE : S_DATA;
                    rx_cnt_d = rx_div_q - DIV_W'(1);
                    rx_bit_d = 3'd0;
                end
            end
            S_DATA: begin
                rx_cnt_d = rx_cnt_q - DIV_W'(1);
                if (rx_cnt_q == '0) begin
                    rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
                    rx_cnt_d = rx_div_q - DIV_W'(1);
                    rx_bit_d = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_st_d = S_STOP;
                end
            end
            S_STOP: begin
                rx_cnt_d = rx_cnt_q - DIV_W'(1);
                if (rx_cnt_q == '0) begin
                    rx_st_d = S_IDLE;
                    if (rx_s2_q) begin
                        rx_push = 1'b1;
                        ovf_set = rx_full & ~rx_pop;
                    end else begin
                        ferr_set = 1'b1;
                    end
                end
            end
            default: rx_st_d = S_IDLE;
        endcase
        if (!rxen_q) begin
            rx_st_d = S_IDLE; rx_push = 1'b0; ovf_set = 1'b0; ferr_set = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txen_q <= 1'b1; rxen_q <= 1'b1; ctsen_q <= 1'b0;
            ovf_q  <= 1'b0; ferr_q <= 1'b0; ie_q <= 3'd0; div_q <= DIV_RESET;
            rx_s1_q <= 1'b1; rx_s2_q <= 1'b1; rx_prev_q <= 1'b1;
            cts_s1_q <= 1'b1; cts_s2_q <= 1'b1;
            tx_st_q <= S_IDLE; tx_cnt_q <= '0; tx_div_q <= '0; tx_bit_q <= '0; tx_sh_q <= '0;
            rx_st_q <= S_IDLE; rx_cnt_q <= '0; rx_div_q <= '0; rx_bit_q <= '0; rx_sh_q <= '0;
        end else begin
            txen_q <= txen_d; rxen_q <= rxen_d; ctsen_q <= ctsen_d;
            ovf_q  <= ovf_d;  ferr_q <= ferr_d; ie_q <= ie_d; div_q <= div_d;
            rx_s1_q <= rx; rx_s2_q <= rx_s1_q; rx_prev_q <= rx_s2_q;
            cts_s1_q <= cts; cts_s2_q <= cts_s1_q;
            tx_st_q <= tx_st_d; tx_cnt_q <= tx_cnt_d; tx_div_q <= tx_div_d;
            tx_bit_q <= tx_bit_d; tx_sh_q <= tx_sh_d;
            rx_st_q <= rx_st_d; rx_cnt_q <= rx_cnt_d; rx_div_q <= rx_div_d;
            rx_bit_q <= rx_bit_d; rx_sh_q <= rx_sh_d;
        end
    end
endmodule

// File: doc/uart_fifo.md
# uart_fifo

Parametrised APB UART that replaces the single-byte, transmit-only UART in the SoC peripheral set. It adds programmable baud divisor, a full receive path, parametrised TX/RX FIFOs, and optional CTS/RTS hardware flow control. It also adds level interrupts and a TX DMA request. It sits on the peripheral APB bus beside the other `libfpga` peripherals. The frame format is fixed 8N1: 1 start bit, 8 data bits LSB first, 1 stop bit.

## Interface
- `FIFO_DEPTH`, 8: entries per FIFO; power of two, ≥2.
- `DIV_W`, 16: width of the baud divisor register.
- `DIV_RESET`, 16'd868: divisor after reset (clocks per bit).
- `clk` in 1: sole clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `apbs_psel`, `apbs_penable`, `apbs_pwrite` in 1: APB control.
- `apbs_paddr` in 16: byte address; only bits [4:2] decoded.
- `apbs_pwdata` in 32: write data.
- `apbs_prdata` out 32: read data.
- `apbs_pready` out 1: tied 1; zero wait states.
- `apbs_pslverr` out 1: 1 during access phase to an unmapped offset (0x18, 0x1C).
- `rx` in 1: serial input, idle high.
- `tx` out 1: serial output, idle high.
- `cts` in 1: clear-to-send, active-low.
- `rts` out 1: request-to-send, active-low.
- `irq` out 1: level interrupt.
- `dreq` out 1: TX DMA request.

## Operation
Register offsets:
- **0x00 CSR**
  - RW: [0] TXEN (reset 1), [1] RXEN (reset 1), [2] CTSEN (reset 0).
  - RO: [8] TX empty, [9] TX full, [10] RX empty, [11] RX full, [12] TX busy.
  - Sticky, write-1-clear: [13] RX overflow, [14] framing error.
- **0x04 DIV**: [DIV_W-1:0] clocks per bit; values <4 behave as 4.
- **0x08 FSTAT**: [7:0] TX level, [15:8] RX level (RO).
- **0x0C TX**: a write pushes [7:0]. If TX is full and there is no same-cycle pop, the write is dropped silently. Reads return 0.
- **0x10 RX**: a read returns {23'h0, empty, data}. The read pops only if RX is not empty; if empty, it returns 0x100.
- **0x14 IE**: [0] TX-empty, [1] RX-not-empty, [2] error (overflow | framing). `irq` = OR of enabled conditions.

Bus rules:
- Register write occurs on `psel & penable & pwrite`.
- RX pop occurs on `psel & penable & !pwrite` at 0x10.
- `apbs_prdata` is combinational from `paddr` while `psel & !pwrite`, and 0 otherwise.

Input synchronisation: `rx` and `cts` each pass through a 2-flop synchroniser that resets to 1.

TX FSM (IDLE, START, DATA, STOP):
- IDLE→START when TXEN, TX not empty, and (!CTSEN | cts==0). The FIFO pops on that transition.
- The divisor is latched per frame, so a DIV write mid-frame takes effect from the next frame.
- Each state holds `tx` for DIV clocks. DATA shifts 8 bits, then STOP drives 1 for DIV clocks, then IDLE.
- Clearing TXEN or deasserting CTS mid-frame does not abort the frame; it blocks the next one.
- TX busy = FSM not IDLE.

RX FSM (IDLE, START, DATA, STOP):
- A falling synchronised `rx` in IDLE (RXEN=1) enters START.
- START samples at DIV/2 clocks. If high, it is a false start: return to IDLE with nothing pushed.
- DATA samples each bit DIV clocks after the previous sample. STOP samples once more.
- Stop=1 pushes the byte. If RX is full, the byte is discarded and overflow is set; a CPU pop in the same cycle makes room, so the push succeeds.
- Stop=0 sets the framing error flag and discards the byte.
- RXEN=0 forces IDLE immediately; the partial byte is lost.

Flow control and DMA:
- `rts` = 1 when RX level ≥ FIFO_DEPTH-1 or RXEN=0; otherwise 0.
- `dreq` = TXEN & TX not full.

FIFO rules:
- Simultaneous push and pop leaves the level unchanged.
- Level width is clog2(FIFO_DEPTH)+1.
- Pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset values:
  - `tx`=1, `rts`=0 (RXEN=1 and RX empty), `irq`=0, `dreq`=1, `apbs_prdata`=0, `apbs_pslverr`=0.
  - FIFOs empty, flags 0, IE=0, DIV=DIV_RESET.
- Reset mid-frame: `tx` returns to 1 asynchronously and both FIFOs are flushed.
- TX latency: the write access phase is cycle N; the FIFO holds the entry at N+1; `tx` falls at N+2 if the FSM was idle and CTS permits.
- A frame lasts exactly 10×DIV clocks. Back-to-back frames from a non-empty FIFO have no idle gap.
- RX latency: a byte is visible (RX not empty) 1 cycle after the STOP sample. The STOP sample occurs 2 sync cycles + DIV/2 + 9×DIV after the `rx` falling edge.
- Status bits and `irq` update the cycle after the causing event.

## Test plan
- DIV=4, write 0x55 to TX → `tx` low at N+2, then bits 1,0,1,0,1,0,1,0 then 1, 4 clocks each; TX busy clears after 40 clocks.
- Write 9 bytes with FIFO_DEPTH=8 and `tx` halted by CTSEN=1, cts=1 → TX full=1, FSTAT TX level=8, 9th byte dropped; release cts → 8 frames emitted in order, no gaps.
- Loop `tx` to `rx`, send 0xA3 → RX reads 0x0A3, next read returns 0x100; IE[1]=1 gives `irq` high while RX not empty.
- Drive 9 frames into `rx` without popping (DEPTH 8) → `rts`=1 after the 7th byte; 9th discarded; CSR[13]=1; writing 0x2000 to CSR clears it.
- Frame with stop bit 0 → CSR[14]=1, nothing pushed; 1-DIV/4-wide low glitch on `rx` → false start, no flags, no push.
- Assert `rst_n` low mid-TX frame → `tx`=1 immediately, FSTAT=0, DIV=DIV_RESET, access to 0x18 gives `apbs_pslverr`=1.
